llfifo_rr_scheduler: RTL

//  Round-robin scheduler in front of linked_list_fifo (NUM_FIFOS virtual queues sharing one DEPTH-entry store).

---
 rtl/llfifo_pkg.sv | 18 +
 rtl/llfifo_rr_arb.sv | 32 +++
 rtl/llfifo_rr_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/llfifo_pkg.sv
// llfifo_pkg: width helpers shared by the round-robin scheduler and its arbiter.
// Ports: none (package only).
package llfifo_pkg;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

  // Index following idx on a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/llfifo_rr_arb.sv
// llfifo_rr_arb: round-robin picker, first request at or after i_base wins.
// Ports: i_req (request vector), i_base (start index), o_gnt (one-hot), o_idx, o_any.
module llfifo_rr_arb
  import llfifo_pkg::*;
#(
  parameter int N  = 2,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_base,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int q;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    q     = 0;
    for (int k = 0; k < N; k++) begin
      q = (int'(i_base) + k) % N;
      if (!o_any && i_req[q]) begin
        o_gnt[q] = 1'b1;
        o_idx    = SW'(q);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llfifo_rr_scheduler.sv
// llfifo_rr_scheduler: RR push arbitration with per-queue cap and RR drain into a
// one-entry valid/ready stage. Ports: push_req/data/gnt, out_*, ff_* to the list store.
module llfifo_rr_scheduler
  import llfifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int NUM_FIFOS = 2,
  parameter int CAP       = DEPTH,
  parameter int SEL_WIDTH = sel_w(NUM_FIFOS),
  parameter int CNT_WIDTH = cnt_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FIFOS-1:0]       push_req,
  input  logic [NUM_FIFOS*WIDTH-1:0] push_data,
  output logic [NUM_FIFOS-1:0]       push_gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_WIDTH-1:0]       out_sel,
  output logic                       ff_push,
  output logic [SEL_WIDTH-1:0]       ff_push_sel,
  output logic [WIDTH-1:0]           ff_data_in,
  output logic                       ff_pop,
  output logic [SEL_WIDTH-1:0]       ff_pop_sel,
  input  logic                       ff_full,
  input  logic [NUM_FIFOS-1:0]       ff_empty,
  input  logic [WIDTH-1:0]           ff_data_out
);

  localparam logic [CNT_WIDTH-1:0] CAP_C = CNT_WIDTH'(CAP);

  logic [SEL_WIDTH-1:0] r_push_ptr;
  logic [SEL_WIDTH-1:0] r_pop_ptr;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_FIFOS];

  logic [NUM_FIFOS-1:0] w_elig;
  logic [NUM_FIFOS-1:0] w_push_oh;
  logic [NUM_FIFOS-1:0] w_pop_oh;
  logic [NUM_FIFOS-1:0] w_pop_hot;
  logic [SEL_WIDTH-1:0] w_push_idx;
  logic [SEL_WIDTH-1:0] w_pop_idx;
  logic                 w_push_any;
  logic                 w_pop_any;
  logic                 w_slot_free;

  // Cap uses the registered count only; a pop this cycle frees no credit.
  always_comb begin
    w_elig = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      w_elig[q] = push_req[q] & (r_cnt[q] < CAP_C) & ~ff_full;
    end
  end

  llfifo_rr_arb #(
    .N  (NUM_FIFOS),
    .SW (SEL_WIDTH)
  ) u_push_arb (
    .i_req  (w_elig),
    .i_base (r_push_ptr),
    .o_gnt  (w_push_oh),
    .o_idx  (w_push_idx),
    .o_any  (w_push_any)
  );

  llfifo_rr_arb #(
    .N  (NUM_FIFOS),
    .SW (SEL_WIDTH)
  ) u_pop_arb (
    .i_req  (~ff_empty),
    .i_base (r_pop_ptr),
    .o_gnt  (w_pop_oh),
    .o_idx  (w_pop_idx),
    .o_any  (w_pop_any)
  );

  assign w_slot_free = ~out_valid | out_ready;

  assign ff_push     = w_push_any & ~rst;
  assign push_gnt    = rst ? '0 : w_push_oh;
  assign ff_push_sel = ff_push ? w_push_idx : '0;

  assign ff_pop      = w_slot_free & w_pop_any & ~rst;
  assign ff_pop_sel  = ff_pop ? w_pop_idx : '0;
  assign w_pop_hot   = ff_pop ? w_pop_oh : '0;

  always_comb begin
    ff_data_in = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      if (push_gnt[q]) ff_data_in = push_data[q*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_ptr <= '0;
      r_pop_ptr  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      for (int q = 0; q < NUM_FIFOS; q++) r_cnt[q] <= '0;
    end else begin
      if (ff_push) begin
        r_push_ptr <= SEL_WIDTH'(rr_next(int'(w_push_idx), NUM_FIFOS));
      end
      if (ff_pop) begin
        out_valid <= 1'b1;
        out_data  <= ff_data_out;
        out_sel   <= w_pop_idx;
        r_pop_ptr <= SEL_WIDTH'(rr_next(int'(w_pop_idx), NUM_FIFOS));
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      for (int q = 0; q < NUM_FIFOS; q++) begin
        r_cnt[q] <= r_cnt[q]
                  + CNT_WIDTH'(push_gnt[q])
                  - CNT_WIDTH'(w_pop_hot[q]);
      end
    end
  end

endmodule
